// File: rtl/reg_arb_pkg.sv
// Shared types for the register-bank arbiter: FSM state, access owner and read-latency limits.
// The request struct is declared in the top because its field widths are module parameters.
package reg_arb_pkg;

  localparam int RD_LAT_MAX = 3;
  localparam int RD_CNT_W   = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_SPI,
    OWN_HOST
  } arb_owner_t;

endpackage

// File: rtl/reg_arb_req_buf.sv
// One-entry holding register for SPI strobes. The entry stays valid until the arbiter
// finishes the access; a push in the same cycle as the pop is accepted.
module reg_arb_req_buf #(
  parameter type req_t = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_req,
  input  logic push_dual,
  input  logic pop,
  output logic full,
  output req_t head,
  output logic ovf
);

  logic valid_q, valid_d;
  req_t data_q, data_d;
  logic ovf_q, ovf_d;
  logic full_eff;
  logic accept;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    full_eff = valid_q & ~pop;
    accept   = push & ~full_eff;
    valid_d  = valid_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      data_d  = push_req;
    end
    if ((push & full_eff) | push_dual) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the payload is reset as well
  // because it is a single register, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full = valid_q;
  assign head = data_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one register-bank port between single-cycle SPI strobes (absolute priority) and a host
// req/ack port. Define REG_ARB_WPROT_EN to drop SPI writes at or above RO_BASE.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int          DWIDTH  = 16,
  parameter int          ALINES  = 7,
  parameter int          RD_LAT  = 1,
  parameter int unsigned RO_BASE = 'h60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr,
  input  logic              spi_rd,
  input  logic [ALINES-1:0] spi_addr,
  input  logic [DWIDTH-1:0] spi_wr_data,
  output logic [DWIDTH-1:0] spi_rd_data,
  output logic              spi_ovf,
  output logic              spi_wr_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ALINES-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic              host_ack,
  output logic [DWIDTH-1:0] host_rdata,
  output logic              bank_we,
  output logic              bank_re,
  output logic [ALINES-1:0] bank_addr,
  output logic [DWIDTH-1:0] bank_wdata,
  input  logic [DWIDTH-1:0] bank_rdata
);

  typedef struct packed {
    logic              we;
    logic [ALINES-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } reg_req_t;

`ifdef REG_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                cur_we_q, cur_we_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                host_abort_q, host_abort_d;
  logic                bank_we_q, bank_we_d;
  logic                bank_re_q, bank_re_d;
  logic [ALINES-1:0]   bank_addr_q, bank_addr_d;
  logic [DWIDTH-1:0]   bank_wdata_q, bank_wdata_d;
  logic                host_ack_q, host_ack_d;
  logic [DWIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic [DWIDTH-1:0]   spi_rd_data_q, spi_rd_data_d;
  logic                spi_wr_err_q, spi_wr_err_d;

  logic     spi_push;
  reg_req_t spi_req;
  logic     buf_full;
  reg_req_t buf_head;
  logic     buf_pop;
  reg_req_t launch_req;
  logic     spi_wr_prot;

  // A simultaneous wr+rd keeps the write: the read strobe is simply not encoded.
  assign spi_push = spi_wr | spi_rd;
  assign spi_req  = '{we: spi_wr, addr: spi_addr, wdata: spi_wr_data};

  reg_arb_req_buf #(
    .req_t(reg_req_t)
  ) u_req_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (spi_push),
    .push_req (spi_req),
    .push_dual(spi_wr & spi_rd),
    .pop      (buf_pop),
    .full     (buf_full),
    .head     (buf_head),
    .ovf      (spi_ovf)
  );

  // A held entry is older than any strobe arriving now, and such a strobe is dropped anyway.
  assign launch_req  = buf_full ? buf_head : spi_req;
  assign spi_wr_prot = WPROT_EN && launch_req.we && (launch_req.addr >= ALINES'(RO_BASE));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cur_we_d      = cur_we_q;
    rd_cnt_d      = rd_cnt_q;
    host_abort_d  = host_abort_q;
    bank_we_d     = 1'b0;
    bank_re_d     = 1'b0;
    bank_addr_d   = bank_addr_q;
    bank_wdata_d  = bank_wdata_q;
    host_ack_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    spi_rd_data_d = spi_rd_data_q;
    spi_wr_err_d  = spi_wr_err_q;
    buf_pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (buf_full || spi_push) begin
          state_d      = ACCESS;
          owner_d      = OWN_SPI;
          cur_we_d     = launch_req.we;
          bank_we_d    = launch_req.we && !spi_wr_prot;
          bank_re_d    = !launch_req.we;
          bank_addr_d  = launch_req.addr;
          bank_wdata_d = launch_req.wdata;
          if (spi_wr_prot) begin
            spi_wr_err_d = 1'b1;
          end
        end else if (host_req && !host_ack_q) begin
          // host_req seen together with host_ack belongs to the request just acknowledged.
          state_d      = ACCESS;
          owner_d      = OWN_HOST;
          cur_we_d     = host_we;
          host_abort_d = 1'b0;
          bank_we_d    = host_we;
          bank_re_d    = !host_we;
          bank_addr_d  = host_addr;
          bank_wdata_d = host_wdata;
        end
      end

      ACCESS: begin
        if (owner_q == OWN_HOST && !host_req) begin
          host_abort_d = 1'b1;
        end
        if (cur_we_q) begin
          state_d = IDLE;
          if (owner_q == OWN_SPI) begin
            buf_pop = 1'b1;
          end else begin
            host_ack_d = host_req && !host_abort_q;
          end
        end else begin
          state_d  = RD_WAIT;
          rd_cnt_d = RD_CNT_W'(RD_LAT - 1);
        end
      end

      RD_WAIT: begin
        if (owner_q == OWN_HOST && !host_req) begin
          host_abort_d = 1'b1;
        end
        if (rd_cnt_q == '0) begin
          state_d = IDLE;
          if (owner_q == OWN_SPI) begin
            spi_rd_data_d = bank_rdata;
            buf_pop       = 1'b1;
          end else if (host_req && !host_abort_q) begin
            host_ack_d   = 1'b1;
            host_rdata_d = bank_rdata;
          end
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_SPI;
      cur_we_q      <= 1'b0;
      rd_cnt_q      <= '0;
      host_abort_q  <= 1'b0;
      bank_we_q     <= 1'b0;
      bank_re_q     <= 1'b0;
      bank_addr_q   <= '0;
      bank_wdata_q  <= '0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
      spi_rd_data_q <= '0;
      spi_wr_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cur_we_q      <= cur_we_d;
      rd_cnt_q      <= rd_cnt_d;
      host_abort_q  <= host_abort_d;
      bank_we_q     <= bank_we_d;
      bank_re_q     <= bank_re_d;
      bank_addr_q   <= bank_addr_d;
      bank_wdata_q  <= bank_wdata_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
      spi_rd_data_q <= spi_rd_data_d;
      spi_wr_err_q  <= spi_wr_err_d;
    end
  end

  assign bank_we     = bank_we_q;
  assign bank_re     = bank_re_q;
  assign bank_addr   = bank_addr_q;
  assign bank_wdata  = bank_wdata_q;
  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign spi_rd_data = spi_rd_data_q;
  assign spi_wr_err  = spi_wr_err_q;

endmodule
